// File: rtl/bexkat1Def.sv
// Shared definitions for the bexkat1 pipeline: instruction fields, type and op codes,
// condition-code layout and the exe-stage output payload.
package bexkat1Def;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned IR_W        = 64;
   localparam int unsigned RW_W        = 2;
   localparam int unsigned CCR_W       = 3;
   localparam int unsigned SHAMT_W     = 5;
   localparam int unsigned SUM_W       = WORD_W + 1;
   localparam int unsigned MUL_STEPS   = 32;
   localparam int unsigned CNT_W       = 5;
   localparam int unsigned LINK_OFFSET = 8;

   // Condition-code bit positions within ccr
   localparam int unsigned CCR_Z = 0;
   localparam int unsigned CCR_N = 1;
   localparam int unsigned CCR_C = 2;

   typedef enum logic [3:0] {
      T_ALU    = 4'h0,
      T_LOAD   = 4'h2,
      T_STORE  = 4'h3,
      T_BRANCH = 4'h4,
      T_JUMP   = 4'h5
   } insn_type_t;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SHL = 4'd5,
      ALU_SHR = 4'd6,
      ALU_ASR = 4'd7,
      ALU_MUL = 4'd8
   } alu_op_t;

   typedef enum logic [3:0] {
      BR_ALWAYS = 4'd0,
      BR_EQ     = 4'd1,
      BR_NE     = 4'd2,
      BR_MI     = 4'd3,
      BR_CS     = 4'd4
   } br_cond_t;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

   // Instruction word as delivered by decode
   typedef struct packed {
      logic [WORD_W-1:0] imm;
      logic [3:0]        itype;
      logic [3:0]        op;
      logic [22:0]       rsvd;
      logic              size;
   } ir_t;

   // Registered payload handed to the mem stage
   typedef struct packed {
      logic [IR_W-1:0]   ir;
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] result;
      logic [WORD_W-1:0] reg_data1;
      logic [RW_W-1:0]   reg_write;
      logic [CCR_W-1:0]  ccr;
      logic              halt;
      logic              pc_set;
      logic [WORD_W-1:0] pc_target;
   } exe_out_t;

   // Branch condition evaluated against the architectural condition codes
   function automatic logic br_taken(input logic [3:0] cond, input logic [CCR_W-1:0] ccr);
      logic taken;
      case (cond)
         BR_ALWAYS: taken = 1'b1;
         BR_EQ:     taken = ccr[CCR_Z];
         BR_NE:     taken = ~ccr[CCR_Z];
         BR_MI:     taken = ccr[CCR_N];
         BR_CS:     taken = ccr[CCR_C];
         default:   taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/mulseq.sv
// Sequential shift-add multiplier: one partial product per cycle, low word of the
// unsigned product. hold_i freezes the FSM, counter and accumulator.
module mulseq
   import bexkat1Def::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              hold_i,
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   output logic              busy_c,
   output logic              done_c,
   output logic [WORD_W-1:0] product_o
);

   mul_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] a_q, a_d;
   logic [WORD_W-1:0] b_q, b_d;
   logic [WORD_W-1:0] acc_q, acc_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= MUL_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      if (!hold_i) begin
         case (state_q)
            MUL_IDLE: begin
               if (start_i) begin
                  state_d = MUL_BUSY;
                  cnt_d   = '0;
                  a_d     = a_i;
                  b_d     = b_i;
                  acc_d   = '0;
               end
            end
            MUL_BUSY: begin
               // Add the shifted multiplicand when the current multiplier bit is set
               acc_d = acc_q + (b_q[0] ? a_q : '0);
               a_d   = a_q << 1;
               b_d   = b_q >> 1;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(MUL_STEPS - 1)) begin
                  state_d = MUL_DONE;
               end
            end
            MUL_DONE: begin
               state_d = MUL_IDLE;
               cnt_d   = '0;
            end
            default: begin
               state_d = MUL_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // A pending start counts as busy so upstream keeps the instruction in place
   assign busy_c    = (state_q == MUL_BUSY) || ((state_q == MUL_IDLE) && start_i);
   assign done_c    = (state_q == MUL_DONE);
   assign product_o = acc_q;

endmodule

// File: rtl/exe.sv
// Execute stage: ALU, load/store address generation, branch/jump resolution and the
// sequential multiplier, all feeding a single registered mem-stage payload.
module exe
   import bexkat1Def::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IR_W-1:0]   ir_i,
   input  logic [WORD_W-1:0] pc_i,
   input  logic [WORD_W-1:0] reg_data1_i,
   input  logic [WORD_W-1:0] reg_data2_i,
   input  logic [RW_W-1:0]   reg_write_i,
   input  logic              halt_i,
   input  logic              stall_i,
   output logic [IR_W-1:0]   ir_o,
   output logic [WORD_W-1:0] pc_o,
   output logic [WORD_W-1:0] result_o,
   output logic [WORD_W-1:0] reg_data1_o,
   output logic [RW_W-1:0]   reg_write_o,
   output logic [CCR_W-1:0]  ccr_o,
   output logic              halt_o,
   output logic              pc_set_o,
   output logic [WORD_W-1:0] pc_target_o,
   output logic              stall_o
);

   ir_t               ir_in;
   logic [WORD_W-1:0] op_a, op_b;
   logic [WORD_W-1:0] alu_res;
   logic [SUM_W-1:0]  alu_sum;
   logic              alu_carry;
   logic              is_mul;
   logic              mul_busy, mul_done;
   logic [WORD_W-1:0] mul_product;
   exe_out_t          exec_res;
   exe_out_t          out_q, out_d;

   assign ir_in  = ir_i;
   assign op_a   = reg_data1_i;
   assign op_b   = ir_in.size ? ir_in.imm : reg_data2_i;
   assign is_mul = (ir_in.itype == T_ALU) && (ir_in.op == ALU_MUL);

   mulseq u_mulseq (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (is_mul),
      .hold_i    (stall_i),
      .a_i       (op_a),
      .b_i       (op_b),
      .busy_c    (mul_busy),
      .done_c    (mul_done),
      .product_o (mul_product)
   );

   // ALU datapath; MUL takes the sequential product, only consumed once it is done
   always_comb begin
      alu_sum   = SUM_W'(op_a) + SUM_W'(op_b);
      alu_res   = op_a;
      alu_carry = 1'b0;
      case (ir_in.op)
         ALU_ADD: begin
            alu_res   = alu_sum[WORD_W-1:0];
            alu_carry = alu_sum[WORD_W];
         end
         ALU_SUB: begin
            alu_res   = op_a - op_b;
            alu_carry = (op_a < op_b);
         end
         ALU_AND: alu_res = op_a & op_b;
         ALU_OR:  alu_res = op_a | op_b;
         ALU_XOR: alu_res = op_a ^ op_b;
         ALU_SHL: alu_res = op_a << op_b[SHAMT_W-1:0];
         ALU_SHR: alu_res = op_a >> op_b[SHAMT_W-1:0];
         ALU_ASR: alu_res = WORD_W'($signed(op_a) >>> op_b[SHAMT_W-1:0]);
         ALU_MUL: alu_res = mul_product;
         default: alu_res = op_a;
      endcase
   end

   // Payload the current instruction would produce if it advanced this cycle
   always_comb begin
      exec_res           = '0;
      exec_res.ir        = ir_in;
      exec_res.pc        = pc_i;
      exec_res.reg_data1 = reg_data1_i;
      exec_res.reg_write = reg_write_i;
      exec_res.halt      = halt_i;
      exec_res.ccr       = out_q.ccr;
      exec_res.result    = op_b;
      case (ir_in.itype)
         T_ALU: begin
            exec_res.result       = alu_res;
            exec_res.ccr[CCR_C]   = alu_carry;
            exec_res.ccr[CCR_N]   = alu_res[WORD_W-1];
            exec_res.ccr[CCR_Z]   = (alu_res == '0);
         end
         T_LOAD, T_STORE: begin
            exec_res.result = reg_data2_i + ir_in.imm;
         end
         T_BRANCH: begin
            exec_res.pc_target = pc_i + ir_in.imm;
            exec_res.pc_set    = br_taken(ir_in.op, out_q.ccr);
         end
         T_JUMP: begin
            exec_res.pc_target = ir_in.imm;
            exec_res.pc_set    = 1'b1;
            exec_res.result    = pc_i + WORD_W'(LINK_OFFSET);
         end
         default: ;
      endcase
   end

   // Output register: hold on stall, bubble while the multiplier owns the stage
   always_comb begin
      out_d = out_q;
      if (!stall_i) begin
         if (mul_done || !mul_busy) begin
            out_d = exec_res;
         end else begin
            out_d     = '0;
            out_d.ccr = out_q.ccr;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign ir_o        = out_q.ir;
   assign pc_o        = out_q.pc;
   assign result_o    = out_q.result;
   assign reg_data1_o = out_q.reg_data1;
   assign reg_write_o = out_q.reg_write;
   assign ccr_o       = out_q.ccr;
   assign halt_o      = out_q.halt;
   assign pc_set_o    = out_q.pc_set;
   assign pc_target_o = out_q.pc_target;

   // Reset abandons any multiply, so only an external hold may keep the stage stalled
   assign stall_o = stall_i | (mul_busy & ~rst_i);

endmodule

// File: tb/tb_exe.sv
// Directed bench for the execute stage: a behavioural model checked every cycle plus
// hand-computed literals at the interesting points.
`timescale 1ns/1ps
module tb_exe;
   import bexkat1Def::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [63:0] ir_i;
   logic [31:0] pc_i, reg_data1_i, reg_data2_i;
   logic [1:0]  reg_write_i;
   logic        halt_i, stall_i;
   logic [63:0] ir_o;
   logic [31:0] pc_o, result_o, reg_data1_o, pc_target_o;
   logic [1:0]  reg_write_o;
   logic [2:0]  ccr_o;
   logic        halt_o, pc_set_o, stall_o;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   exe dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .ir_i        (ir_i),
      .pc_i        (pc_i),
      .reg_data1_i (reg_data1_i),
      .reg_data2_i (reg_data2_i),
      .reg_write_i (reg_write_i),
      .halt_i      (halt_i),
      .stall_i     (stall_i),
      .ir_o        (ir_o),
      .pc_o        (pc_o),
      .result_o    (result_o),
      .reg_data1_o (reg_data1_o),
      .reg_write_o (reg_write_o),
      .ccr_o       (ccr_o),
      .halt_o      (halt_o),
      .pc_set_o    (pc_set_o),
      .pc_target_o (pc_target_o),
      .stall_o     (stall_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   exe_out_t m     = '0;
   int       m_rem = 0;   // unstalled edges left until a multiply completes
   logic     in_is_mul;

   assign in_is_mul = (ir_i[31:28] == T_ALU) && (ir_i[27:24] == 4'd8);

   function automatic exe_out_t model_exec(input logic [63:0] ir, input logic [31:0] pc,
                                           input logic [31:0] a, input logic [31:0] rb,
                                           input logic [1:0] rw, input logic h,
                                           input logic [2:0] ccr);
      exe_out_t    o;
      logic [31:0] imm, b, r;
      logic [63:0] wide;
      logic [3:0]  op;
      logic        c, taken;
      int          sh;
      imm         = ir[63:32];
      op          = ir[27:24];
      b           = ir[0] ? imm : rb;
      sh          = int'(b[4:0]);
      o           = '0;
      o.ir        = ir;
      o.pc        = pc;
      o.reg_data1 = a;
      o.reg_write = rw;
      o.halt      = h;
      o.ccr       = ccr;
      o.result    = b;
      c           = 1'b0;
      r           = a;
      case (ir[31:28])
         T_ALU: begin
            case (op)
               4'd0: begin wide = {32'd0, a} + {32'd0, b}; r = wide[31:0]; c = wide[32]; end
               4'd1: begin r = a - b; c = (a < b); end
               4'd2: r = a & b;
               4'd3: r = a | b;
               4'd4: r = a ^ b;
               4'd5: r = a << sh;
               4'd6: r = a >> sh;
               4'd7: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
               4'd8: begin wide = {32'd0, a} * {32'd0, b}; r = wide[31:0]; end
               default: r = a;
            endcase
            o.result = r;
            o.ccr    = {c, r[31], r == 32'd0};
         end
         T_LOAD, T_STORE: o.result = rb + imm;
         T_BRANCH: begin
            taken = (op == 4'd0) || (op == 4'd1 && ccr[0]) || (op == 4'd2 && !ccr[0]) ||
                    (op == 4'd3 && ccr[1]) || (op == 4'd4 && ccr[2]);
            o.pc_target = pc + imm;
            o.pc_set    = taken;
         end
         T_JUMP: begin
            o.pc_target = imm;
            o.pc_set    = 1'b1;
            o.result    = pc + 32'd8;
         end
         default: ;
      endcase
      return o;
   endfunction

   function automatic exe_out_t bubble(input logic [2:0] ccr);
      exe_out_t o;
      o     = '0;
      o.ccr = ccr;
      return o;
   endfunction

   always @(posedge clk_i) begin
      if (rst_i) begin
         m     <= '0;
         m_rem <= 0;
      end else if (!stall_i) begin
         if (m_rem == 0 && in_is_mul) begin
            m_rem <= 33;
            m     <= bubble(m.ccr);
         end else if (m_rem > 1) begin
            m_rem <= m_rem - 1;
            m     <= bubble(m.ccr);
         end else begin
            m_rem <= 0;
            m     <= model_exec(ir_i, pc_i, reg_data1_i, reg_data2_i, reg_write_i, halt_i, m.ccr);
         end
      end
   end

   // Per-cycle comparison away from the active edge
   always @(negedge clk_i) begin
      chk("ir_o", ir_o, m.ir);
      chk("pc_o", pc_o, m.pc);
      chk("result_o", result_o, m.result);
      chk("reg_data1_o", reg_data1_o, m.reg_data1);
      chk("reg_write_o", reg_write_o, m.reg_write);
      chk("ccr_o", ccr_o, m.ccr);
      chk("halt_o", halt_o, m.halt);
      chk("pc_set_o", pc_set_o, m.pc_set);
      chk("pc_target_o", pc_target_o, m.pc_target);
      chk("stall_o", stall_o,
          stall_i | (!rst_i && ((m_rem > 1) || (m_rem == 0 && in_is_mul))));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic apply(input logic [3:0] t, input logic [3:0] op, input logic sz,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] rw, input logic h);
      ir_i        = {imm, t, op, 23'd0, sz};
      pc_i        = pc;
      reg_data1_i = a;
      reg_data2_i = b;
      reg_write_i = rw;
      halt_i      = h;
   endtask

   task automatic nop();
      apply(4'hF, 4'h0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i   = 1'b1;
      stall_i = 1'b0;
      nop();
      tick();
      chk("reset result_o", result_o, 32'd0);
      chk("reset ccr_o", ccr_o, 3'b000);
      chk("reset ir_o", ir_o, 64'd0);
      chk("reset stall_o", stall_o, 1'b0);
      rst_i = 1'b0;

      // ADD with carry-out to zero
      apply(T_ALU, 4'd0, 1'b0, 32'd0, 32'h10, 32'hFFFF_FFFF, 32'd1, 2'd1, 1'b0);
      tick();
      chk("add result", result_o, 32'd0);
      chk("add ccr", ccr_o, 3'b101);
      // SUB with immediate, borrow
      apply(T_ALU, 4'd1, 1'b1, 32'd5, 32'h18, 32'd3, 32'hDEAD, 2'd2, 1'b0);
      tick();
      chk("sub result", result_o, 32'hFFFF_FFFE);
      chk("sub ccr", ccr_o, 3'b110);
      // BEQ with zero clear: not taken
      apply(T_BRANCH, 4'd1, 1'b1, 32'h20, 32'h100, 32'd0, 32'd0, 2'd0, 1'b0);
      tick();
      chk("beq nt pc_set", pc_set_o, 1'b0);
      apply(T_ALU, 4'd0, 1'b0, 32'd0, 32'h20, 32'd0, 32'd0, 2'd1, 1'b0);
      tick();
      // BEQ with zero set: taken for exactly one cycle
      apply(T_BRANCH, 4'd1, 1'b1, 32'h20, 32'h100, 32'd0, 32'd0, 2'd0, 1'b0);
      tick();
      chk("beq t pc_set", pc_set_o, 1'b1);
      chk("beq t target", pc_target_o, 32'h120);
      nop();
      tick();
      chk("beq after pc_set", pc_set_o, 1'b0);
      // Taken branch held by stall keeps pc_set without re-issue
      apply(T_BRANCH, 4'd0, 1'b1, 32'h40, 32'h200, 32'd0, 32'd0, 2'd0, 1'b0);
      tick();
      nop();
      stall_i = 1'b1;
      tick();
      tick();
      chk("held pc_set", pc_set_o, 1'b1);
      chk("held target", pc_target_o, 32'h240);
      stall_i = 1'b0;
      tick();
      chk("released pc_set", pc_set_o, 1'b0);

      // Assorted ALU ops and conditional branches
      apply(T_ALU, 4'd2, 1'b0, 32'd0, 32'h30, 32'h0000_F0F0, 32'h0000_0FF0, 2'd3, 1'b0); tick();
      apply(T_ALU, 4'd3, 1'b1, 32'h0F00_0000, 32'h34, 32'h0000_F0F0, 32'd0, 2'd1, 1'b0); tick();
      apply(T_ALU, 4'd4, 1'b0, 32'd0, 32'h38, 32'hAAAA_5555, 32'hFFFF_0000, 2'd2, 1'b0); tick();
      apply(T_ALU, 4'd5, 1'b1, 32'd31, 32'h3C, 32'd1, 32'd0, 2'd1, 1'b0); tick();
      chk("shl result", result_o, 32'h8000_0000);
      apply(T_BRANCH, 4'd3, 1'b1, 32'hFFFF_FFF0, 32'h400, 32'd0, 32'd0, 2'd0, 1'b0); tick();
      chk("bmi pc_set", pc_set_o, 1'b1);
      apply(T_ALU, 4'd6, 1'b0, 32'd0, 32'h40, 32'h8000_0000, 32'd4, 2'd1, 1'b0); tick();
      apply(T_ALU, 4'd7, 1'b1, 32'd4, 32'h44, 32'h8000_0000, 32'd0, 2'd1, 1'b0); tick();
      chk("asr result", result_o, 32'hF800_0000);
      apply(T_ALU, 4'd9, 1'b0, 32'd0, 32'h48, 32'h1234_5678, 32'd7, 2'd1, 1'b0); tick();
      apply(T_ALU, 4'd0, 1'b1, 32'd1, 32'h4C, 32'hFFFF_FFFF, 32'd0, 2'd1, 1'b0); tick();
      apply(T_BRANCH, 4'd4, 1'b1, 32'h8, 32'h500, 32'd0, 32'd0, 2'd0, 1'b0); tick();
      apply(T_BRANCH, 4'd7, 1'b1, 32'h8, 32'h504, 32'd0, 32'd0, 2'd0, 1'b0); tick();
      apply(T_BRANCH, 4'd2, 1'b1, 32'h8, 32'h508, 32'd0, 32'd0, 2'd0, 1'b0); tick();
      apply(T_ALU, 4'd1, 1'b0, 32'd0, 32'h50, 32'd77, 32'd77, 2'd1, 1'b0); tick();
      apply(T_LOAD, 4'd0, 1'b1, 32'hFFFF_FFFC, 32'h54, 32'hCAFE, 32'h1000, 2'd1, 1'b0); tick();
      chk("load addr", result_o, 32'h0000_0FFC);
      apply(T_STORE, 4'd0, 1'b1, 32'h10, 32'h58, 32'hBEEF, 32'h2000, 2'd0, 1'b0); tick();
      chk("store data", reg_data1_o, 32'hBEEF);
      apply(T_JUMP, 4'd0, 1'b1, 32'h1000, 32'h300, 32'd0, 32'd0, 2'd1, 1'b0); tick();
      chk("jump link", result_o, 32'h308);
      chk("jump target", pc_target_o, 32'h1000);
      apply(4'hE, 4'd0, 1'b0, 32'd0, 32'h5C, 32'd0, 32'h55, 2'd0, 1'b1); tick();
      chk("halt_o", halt_o, 1'b1);

      // MUL, no stall: 32 bubbles after acceptance, result on the 33rd edge
      apply(T_ALU, 4'd8, 1'b0, 32'd0, 32'h60, 32'h0001_0000, 32'h0001_0001, 2'd1, 1'b0);
      tick();
      chk("mul stall start", stall_o, 1'b1);
      repeat (31) tick();
      chk("mul stall end", stall_o, 1'b1);
      chk("mul bubble ir", ir_o, 64'd0);
      tick();
      chk("mul done stall", stall_o, 1'b0);
      chk("mul pre result", result_o, 32'd0);
      tick();
      chk("mul result", result_o, 32'h0001_0000);
      chk("mul ccr", ccr_o, 3'b000);
      nop();
      tick();

      // MUL with a 3-cycle hold in the middle
      apply(T_ALU, 4'd8, 1'b0, 32'd0, 32'h64, 32'd7, 32'd6, 2'd2, 1'b0);
      tick();
      repeat (9) tick();
      stall_i = 1'b1;
      repeat (3) tick();
      chk("mul hold ir", ir_o, 64'd0);
      stall_i = 1'b0;
      repeat (23) tick();
      chk("mul hold pre", result_o, 32'd0);
      tick();
      chk("mul hold result", result_o, 32'd42);
      nop();
      tick();

      // Reset in the middle of a multiply
      apply(T_ALU, 4'd8, 1'b0, 32'd0, 32'h68, 32'd5, 32'd5, 2'd1, 1'b0);
      tick();
      repeat (9) tick();
      rst_i = 1'b1;
      #1;
      chk("rst stall_o", stall_o, 1'b0);
      chk("rst result_o", result_o, 32'd0);
      chk("rst ccr_o", ccr_o, 3'b000);
      tick();
      rst_i = 1'b0;
      apply(T_ALU, 4'd0, 1'b0, 32'd0, 32'h70, 32'd2, 32'd2, 2'd1, 1'b0);
      tick();
      chk("post rst add", result_o, 32'd4);
      chk("post rst stall", stall_o, 1'b0);
      nop();
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/exe.md
EXE -- requirements
Module: exe

Interface
REQ-001 clk_i  input  1  clock; all state changes on rising edge.
REQ-002 rst_i  input  1  reset, asynchronous, active-high.
REQ-003 ir_i  input  64  instruction from decode: type [31:28], op [27:24], size [0], immediate word [63:32].
REQ-004 pc_i, reg_data1_i, reg_data2_i  input  32 each  instruction PC, store-data/operand-A register, operand-B/base register.
REQ-005 reg_write_i  input  2  register write-enable code, passed through unchanged.
REQ-006 halt_i, stall_i  input  1 each  halt request from decode; hold request from mem.
REQ-007 ir_o, pc_o, result_o, reg_data1_o, reg_write_o, ccr_o (3), halt_o  output  registered mem-stage feed, widths as inputs.
REQ-008 pc_set_o  output  1  registered taken-branch/jump flag; pc_target_o  output  32  registered redirect address.
REQ-009 stall_o  output  1  combinational, = stall_i OR multiplier busy; upstream holds all inputs stable while high.

Function
REQ-010 Operand B SHALL be ir_i[63:32] when ir_i[0]=1, else reg_data2_i; operand A SHALL be reg_data1_i.
REQ-011 T_ALU ops by ir_op: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR logical, 7 ASR, 8 MUL; shift amount B[4:0]; any other op yields result A.
REQ-012 ALU results SHALL be 32-bit, wrapping; MUL yields low 32 bits of unsigned A*B.
REQ-013 ccr = {carry, negative, zero}: carry = bit 32 of ADD, borrow (A<B unsigned) for SUB, 0 otherwise; negative = result[31]; zero = (result==0).
REQ-014 ccr_o SHALL update only when a T_ALU instruction advances; all other types hold it.
REQ-015 T_LOAD/T_STORE: result = reg_data2_i + ir_i[63:32] (wrapping); reg_data1_i passed to reg_data1_o as store data.
REQ-016 T_BRANCH: target = pc_i + ir_i[63:32]; taken by ir_op: 0 always, 1 zero, 2 !zero, 3 negative, 4 carry, others never; condition evaluated on current ccr_o.
REQ-017 T_JUMP: target = ir_i[63:32], always taken; result = pc_i + 8 (link value).
REQ-018 Other types: result = operand B, pc_set = 0.
REQ-019 Single-cycle instructions: outputs valid one clock after acceptance; latency 1.
REQ-020 Multiplier FSM states IDLE, BUSY, DONE: IDLE->BUSY when T_ALU/MUL present and stall_i=0; BUSY counts 32 cycles, one shift-add per cycle; BUSY->DONE after 32nd; DONE->IDLE when stall_i=0, loading MUL result and instruction into outputs.
REQ-021 During BUSY (and DONE with stall_i=1 is hold only), output register SHALL load a bubble when stall_i=0: ir_o=0, reg_write_o=0, pc_set_o=0, halt_o=0.
REQ-022 MUL latency SHALL be 33 cycles from acceptance to outputs with stall_i low throughout.
REQ-023 stall_i=1 SHALL hold every output register and freeze the multiplier counter and accumulator.
REQ-024 pc_set_o SHALL be high for exactly one output cycle per taken branch; a held (stalled) output keeps it high without re-issuing.
REQ-025 halt_o SHALL register halt_i with the instruction it accompanies.

Reset
REQ-026 rst_i SHALL clear ir_o, pc_o, result_o, reg_data1_o, pc_target_o to 0; reg_write_o, ccr_o to 0; pc_set_o, halt_o to 0; FSM to IDLE, counter to 0.
REQ-027 Reset asserted mid-multiply SHALL abandon the operation; stall_o falls with rst_i unless stall_i is high.

Structure
REQ-028 Type codes T_ALU, T_LOAD, T_STORE, T_BRANCH, T_JUMP, ALU op enum, branch-condition enum and ccr bit indices SHALL live in bexkat1Def.
REQ-029 The shift-add multiplier SHALL be sub-module mulseq (start, busy, done, 32-bit A/B/product), FSM inside it.

Verification
REQ-030 ADD A=0xFFFFFFFF, B=1 -> result_o=0, ccr_o=3'b101 next cycle.
REQ-031 SUB A=3, imm B=5 (size=1) -> result_o=0xFFFFFFFE, ccr_o=3'b110.
REQ-032 MUL A=0x10000, B=0x10001 -> stall_o high 32 cycles, 32 bubbles, then result_o=0x00010000 at cycle 33.
REQ-033 BEQ pc_i=0x100, imm 0x20, ccr_o zero=1 -> pc_set_o=1, pc_target_o=0x120 for one cycle; with zero=0 -> pc_set_o=0.
REQ-034 stall_i held 3 cycles mid-MUL -> result arrives at cycle 36, counter frozen, outputs unchanged during hold.
REQ-035 rst_i pulsed at MUL cycle 10 -> all outputs 0, FSM IDLE, next ADD 2+2 yields result_o=4.
